// File: rtl/rom_loader.sv
// Download-side ROM loader: captures the MRA header, packs payload bytes
// into big-endian words and streams them to SDRAM through a small FIFO.
module rom_loader #(
  parameter int HDR_BYTES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 24
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [3:0]    pcb,
  output logic          tate,
  output logic [7:0]    brd,
  output logic          hdr_valid,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_data,
  output logic [1:0]    sdram_be,
  output logic          busy,
  output logic          rom_loaded,
  output logic          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
  } word_t;

  state_t        state;
  logic          dl_q;
  logic          dl_p;
  logic          wr_q;
  logic [24:0]   addr_q;
  logic [7:0]    dout_q;

  logic          pend_v;
  logic [7:0]    pend_byte;
  logic [AW-1:0] pend_addr;
  logic          defer_v;
  word_t         defer_w;

  word_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  logic          rise;
  logic          fall;
  logic [24:0]   off;
  logic [AW-1:0] waddr;
  logic          is_hdr;
  logic          byte_ev;
  logic          pay_ev;
  logic          match;
  logic          full;
  logic          pop;
  logic          push_v;
  logic          push_ok;
  logic          flush;
  word_t         push_w;
  word_t         pend_w;
  word_t         head;

  assign rise    = dl_q & ~dl_p;
  assign fall    = ~dl_q & dl_p;
  assign off     = addr_q - 25'(HDR_BYTES);
  assign waddr   = AW'(off >> 1);
  assign is_hdr  = addr_q < 25'(HDR_BYTES);
  assign byte_ev = wr_q && (state == LOAD);
  assign pay_ev  = byte_ev && !is_hdr;
  assign match   = pend_v && (pend_addr == waddr);
  assign full    = cnt == CW'(FIFO_DEPTH);
  assign pop     = sdram_ack && sdram_req;
  assign push_ok = push_v && (!full || pop);
  assign head    = mem[rp];
  assign pend_w  = {pend_addr, pend_byte, 8'h00, 2'b10};

  // One push per cycle: a deferred odd byte always wins its slot.
  always_comb begin
    push_v = 1'b0;
    push_w = '0;
    flush  = 1'b0;
    unique case (1'b1)
      defer_v: begin
        push_v = 1'b1;
        push_w = defer_w;
      end
      pay_ev: begin
        push_v = off[0] ? 1'b1 : pend_v;
        if (!off[0] || (pend_v && !match))
          push_w = pend_w;
        else if (match)
          push_w = {waddr, pend_byte, dout_q, 2'b11};
        else
          push_w = {waddr, 8'h00, dout_q, 2'b01};
      end
      (pend_v && (state == DRAIN || (state == LOAD && fall))): begin
        push_v = 1'b1;
        push_w = pend_w;
        flush  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      mem[wp] <= push_w;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      dl_p       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      pcb        <= '0;
      tate       <= 1'b0;
      brd        <= '0;
      hdr_valid  <= 1'b0;
      pend_v     <= 1'b0;
      pend_byte  <= '0;
      pend_addr  <= '0;
      defer_v    <= 1'b0;
      defer_w    <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_be   <= '0;
      busy       <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      dl_p   <= dl_q;
      wr_q   <= ioctl_wr;
      addr_q <= ioctl_addr;
      dout_q <= ioctl_dout;
      if (rise && (state == IDLE || state == DONE)) begin
        state      <= LOAD;
        busy       <= 1'b1;
        rom_loaded <= 1'b0;
        hdr_valid  <= 1'b0;
        overflow   <= 1'b0;
        pend_v     <= 1'b0;
        defer_v    <= 1'b0;
        wp         <= '0;
        rp         <= '0;
        cnt        <= '0;
        sdram_req  <= 1'b0;
      end else begin
        if (byte_ev && is_hdr) begin
          if (addr_q == 25'd0) begin
            pcb  <= dout_q[3:0];
            tate <= dout_q[7];
          end else if (addr_q == 25'd1) begin
            brd       <= dout_q;
            hdr_valid <= 1'b1;
          end
        end

        if (defer_v) begin
          defer_v <= 1'b0;
        end else if (pay_ev) begin
          if (!off[0]) begin
            pend_v    <= 1'b1;
            pend_byte <= dout_q;
            pend_addr <= waddr;
          end else if (match) begin
            pend_v <= 1'b0;
          end else if (pend_v) begin
            pend_v  <= 1'b0;
            defer_v <= 1'b1;
            defer_w <= {waddr, 8'h00, dout_q, 2'b01};
          end
        end else if (flush) begin
          pend_v <= 1'b0;
        end

        if (push_ok)
          wp <= wp + 1'b1;
        if (push_v && !push_ok)
          overflow <= 1'b1;
        if (pop)
          rp <= rp + 1'b1;
        unique case ({push_ok, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: ;
        endcase

        // Request drops for one cycle after every ack.
        if (pop) begin
          sdram_req <= 1'b0;
        end else if (!sdram_req && cnt != '0) begin
          sdram_req  <= 1'b1;
          sdram_addr <= head.addr;
          sdram_data <= head.data;
          sdram_be   <= head.be;
        end

        case (state)
          LOAD: begin
            if (fall)
              state <= DRAIN;
          end
          DRAIN: begin
            if (cnt == '0 && !sdram_req && !pend_v && !defer_v) begin
              state      <= DONE;
              busy       <= 1'b0;
              rom_loaded <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Download-side ROM loader between `data_io` and the Alpha68k SDRAM port. It captures the two-byte MRA header into board-configuration registers (`pcb`, `brd`, `tate`) and packs the remaining payload bytes into 16-bit big-endian words. It buffers those words in a small FIFO and writes them to the SDRAM controller through a req/ack handshake. It also generates the `rom_loaded` qualifier that the top level folds into core reset.

## Interface
Parameters:
- `HDR_BYTES`, 2: header length in bytes; payload offset = `ioctl_addr - HDR_BYTES`.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, at least 2.
- `AW`, 24: SDRAM word-address width.

Ports:
- `clk_sys`  in  1: system clock (72 MHz domain). Only clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `ioctl_download`  in  1: download-active level from `data_io`.
- `ioctl_wr`  in  1: one-cycle byte strobe.
- `ioctl_addr`  in  25: byte address of the strobed byte, including the header.
- `ioctl_dout`  in  8: byte data.
- `pcb`  out  4: header byte 0 [3:0].
- `tate`  out  1: header byte 0 [7].
- `brd`  out  8: header byte 1.
- `hdr_valid`  out  1: header byte 1 has been captured during the current download.
- `sdram_req`  out  1: write request, held until acknowledged.
- `sdram_ack`  in  1: one-cycle acknowledge from the SDRAM controller.
- `sdram_addr`  out  AW: word address = payload offset >> 1.
- `sdram_data`  out  16: write data; [15:8] = even payload byte.
- `sdram_be`  out  2: byte enables {hi, lo}.
- `busy`  out  1: the state machine is not in IDLE or DONE.
- `rom_loaded`  out  1: payload fully committed to SDRAM.
- `overflow`  out  1: sticky; at least one word was dropped because the FIFO was full.

## Operation
- Inputs `ioctl_*` are registered once. All decisions below act on these registered copies.
- State machine:
  - IDLE → LOAD on the rising edge of `ioctl_download`.
  - LOAD → DRAIN on the falling edge of `ioctl_download`.
  - DRAIN → DONE when the FIFO is empty, no request is outstanding and no byte is pending.
  - DONE → LOAD on the next rising edge of `ioctl_download`.
- Entering LOAD clears `rom_loaded`, `hdr_valid`, `overflow`, the pending byte and the FIFO pointers.
- Header capture:
  - `ioctl_addr` = 0 loads `pcb` and `tate`.
  - `ioctl_addr` = 1 loads `brd` and sets `hdr_valid`.
  - Header bytes never enter the FIFO.
- Payload packing, with offset o = `ioctl_addr - HDR_BYTES`:
  - Even o: the byte becomes pending as high byte at word address o>>1. If a byte was already pending, that byte is first pushed with `sdram_be` = 10.
  - Odd o matching the pending word address: push {pending, byte} with `sdram_be` = 11 and clear pending.
  - Odd o with no match: push {8'h00, byte} with `sdram_be` = 01. Any unmatched pending byte is pushed on this cycle instead; the odd byte is then pushed on the next cycle. The loader accepts at most one push per cycle, and `data_io` byte spacing (≥ 4 clocks) guarantees room for this.
  - On the falling edge of `ioctl_download`, a pending byte is pushed with `sdram_be` = 10.
- FIFO full on push: the word is dropped and `overflow` is set. There is no backpressure toward `data_io`.
- Handshake:
  - `sdram_req` is high whenever the FIFO is non-empty.
  - `sdram_addr`, `sdram_data` and `sdram_be` show the head entry and stay stable while `sdram_req` is high.
  - `sdram_ack` while `sdram_req` is high pops the head. `sdram_req` drops in the following cycle, even if the FIFO still holds entries, and rises again one cycle later.
  - `sdram_ack` while `sdram_req` is low is ignored.
- A push and a pop in the same cycle are both performed and the occupancy is unchanged. A push into a full FIFO with a simultaneous pop is accepted.
- `rom_loaded` is set on entry to DONE and holds until the next download starts.

## Timing
- Reset values:
  - `pcb` = 0, `tate` = 0, `brd` = 0.
  - `hdr_valid`, `sdram_req`, `busy`, `rom_loaded`, `overflow` all 0.
  - `sdram_addr` = 0, `sdram_data` = 0, `sdram_be` = 0.
  - State = IDLE, FIFO empty.
- `reset_n` low mid-download aborts immediately: `sdram_req` drops in the next cycle and queued words are discarded. The SDRAM controller tolerates a dropped request.
- Latency:
  - `ioctl_wr` on a completing (odd) byte at cycle N → pushed at N+1 → `sdram_req` high at N+2, provided the FIFO was empty.
  - Header registers update at N+1.
- `rom_loaded` rises 1 cycle after the final ack, or 2 cycles after the `ioctl_download` fall if nothing is queued.
- Sustained throughput: one word per 2 clocks minimum.

## Test plan
- Header plus payload: download bytes 0x83, 0x05, 0x12, 0x34, 0x56, 0x78 with immediate acks → `pcb` = 3, `tate` = 1, `brd` = 0x05; writes (0, 0x1234, 11) then (1, 0x5678, 11); `rom_loaded` = 1.
- Odd-length payload: 0x00, 0x00, 0xAB, 0xCD, 0xEF, then the download ends → final write (1, 0xEF00, 10); `rom_loaded` rises only after its ack.
- Backpressure: 6 payload words with acks held off for 200 cycles → `overflow` = 1; exactly 4 writes, addresses 0–3, occur after the acks resume.
- Address gap: payload offsets 0, then 5 → writes (0, 0xXX00, 10) then (2, 0x00YY, 01).
- Mid-download reset: `reset_n` = 0 while `sdram_req` is high → next cycle all outputs are at reset values; a subsequent full download completes normally.
- Spurious ack: `sdram_ack` pulses while the FIFO is empty → no pop, and no change to pointers or outputs.
